// File: rtl/cdc_hs_tx_pkg.sv
// Shared definitions for the four-phase req/ack transmitter:
// FSM state encoding and default widths.
package cdc_hs_tx_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_TMO_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_e;

endpackage

// File: rtl/dff_chain2.sv
// Two-stage synchroniser for a single level signal arriving from another clock domain.
module dff_chain2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

// File: rtl/cdc_hs_tx.sv
// Source-domain side of a four-phase req/ack CDC handshake with
// completion pulse and sticky timeout flag.
module cdc_hs_tx
  import cdc_hs_tx_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int TMO_W = DEF_TMO_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          src_valid,
  output logic          src_ready,
  input  logic [DW-1:0] src_data,
  output logic          tx_req,
  output logic [DW-1:0] tx_data,
  input  logic          tx_ack,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          err_clr
);

  localparam logic [TMO_W-1:0] CNT_MAX = '1;

  state_e           r_state;
  state_e           w_state_next;
  logic             r_req;
  logic             w_req_next;
  logic [DW-1:0]    r_data;
  logic             r_done;
  logic             w_done_next;
  logic             r_err;
  logic             w_err_next;
  logic [TMO_W-1:0] r_cnt;
  logic [TMO_W-1:0] w_cnt_next;
  logic             w_ack_s;
  logic             w_accept;
  logic             w_sat;

  dff_chain2 u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (tx_ack),
    .q     (w_ack_s)
  );

  // A lingering ack in IDLE blocks new words until the receiver has released it.
  assign src_ready = (r_state == IDLE) && !w_ack_s;
  assign w_accept  = src_valid && src_ready;

  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_req;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = REQ;
          w_req_next   = 1'b1;
        end
      end
      REQ: begin
        if (w_ack_s) begin
          w_state_next = REL;
          w_req_next   = 1'b0;
        end
      end
      REL: begin
        if (!w_ack_s) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_req_next   = 1'b0;
      end
    endcase
  end

  // Timeout only flags; the handshake keeps waiting for the ack.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_accept) begin
      w_cnt_next = '0;
    end else if ((r_state == REQ) && (r_cnt != CNT_MAX)) begin
      w_cnt_next = r_cnt + 1'b1;
    end
    w_sat = (w_cnt_next == CNT_MAX) && (r_cnt != CNT_MAX);
    if (w_sat) begin
      w_err_next = 1'b1;
    end else if (err_clr) begin
      w_err_next = 1'b0;
    end else begin
      w_err_next = r_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_req   <= w_req_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_data <= src_data;
      end
    end
  end

  assign tx_req  = r_req;
  assign tx_data = r_data;
  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed bench for cdc_hs_tx: loopback transfers, stale ack, timeout, mid-transfer reset.
module tb_cdc_hs_tx;

  logic        clk;
  logic        rst_n;
  logic        src_valid;
  logic        src_ready;
  logic [31:0] src_data;
  logic        tx_req;
  logic [31:0] tx_data;
  logic        tx_ack;
  logic        busy;
  logic        done;
  logic        err;
  logic        err_clr;

  logic        loop_en;
  logic        ack_force;
  int          n_checks;
  int          n_errors;
  int          dcount;

  assign tx_ack = loop_en ? tx_req : ack_force;

  cdc_hs_tx #(.DW(32), .TMO_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_data  (src_data),
    .tx_req    (tx_req),
    .tx_data   (tx_data),
    .tx_ack    (tx_ack),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    src_valid = 1'b0;
    src_data  = 32'h0;
    loop_en   = 1'b0;
    ack_force = 1'b0;
    err_clr   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_src_ready", {31'd0, src_ready}, 32'd1);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_tx_req",    {31'd0, tx_req},    32'd0);
    chk("rst_tx_data",   tx_data,            32'd0);
    chk("rst_err",       {31'd0, err},       32'd0);
    chk("rst_done",      {31'd0, done},      32'd0);

    // single loopback transfer
    loop_en   = 1'b1;
    src_valid = 1'b1;
    src_data  = 32'hA5A5_0001;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e == 0) src_valid = 1'b0;
      chk($sformatf("lb_req_e%0d", e),  {31'd0, tx_req}, {31'd0, (e < 3)});
      chk($sformatf("lb_done_e%0d", e), {31'd0, done},   {31'd0, (e == 6)});
      chk($sformatf("lb_data_e%0d", e), tx_data,         32'hA5A5_0001);
      $display("single e=%0d req=%0b done=%0b data=%h", e, tx_req, done, tx_data);
    end

    // back-to-back with src_valid held high
    dcount    = 0;
    src_valid = 1'b1;
    src_data  = 32'h1;
    for (int e = 0; e < 21; e++) begin
      tick();
      chk($sformatf("b2b_req_e%0d", e),  {31'd0, tx_req}, {31'd0, ((e % 7) < 3)});
      chk($sformatf("b2b_done_e%0d", e), {31'd0, done},   {31'd0, ((e % 7) == 6)});
      if ((e % 7) == 0) begin
        chk($sformatf("b2b_data_e%0d", e), tx_data, (e / 7) + 1);
        chk($sformatf("b2b_busy_e%0d", e), {31'd0, busy}, 32'd1);
        src_data = (e / 7) + 2;
        if (e == 14) src_valid = 1'b0;
      end
      if (done) dcount++;
      $display("b2b e=%0d req=%0b done=%0b data=%h", e, tx_req, done, tx_data);
    end
    chk("b2b_done_count", dcount, 32'd3);
    tick();
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
    chk("b2b_last_data", tx_data, 32'h3);

    // stale ack in IDLE blocks acceptance
    loop_en   = 1'b0;
    ack_force = 1'b1;
    tick();
    tick();
    src_valid = 1'b1;
    src_data  = 32'hDEAD_BEEF;
    chk("stale_ready", {31'd0, src_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stale_busy_%0d", k), {31'd0, busy},   32'd0);
      chk($sformatf("stale_req_%0d", k),  {31'd0, tx_req}, 32'd0);
      chk($sformatf("stale_data_%0d", k), tx_data,         32'h3);
    end
    ack_force = 1'b0;
    tick();
    chk("stale_rel1_ready", {31'd0, src_ready}, 32'd0);
    tick();
    chk("stale_rel2_ready", {31'd0, src_ready}, 32'd1);
    $display("stale ack released ready=%0b", src_ready);

    // accept with ack tied low and wait for timeout
    tick();
    src_valid = 1'b0;
    chk("tmo_req_e0",  {31'd0, tx_req}, 32'd1);
    chk("tmo_data_e0", tx_data,         32'hDEAD_BEEF);
    for (int e = 1; e <= 14; e++) tick();
    chk("tmo_err_e14", {31'd0, err},    32'd0);
    chk("tmo_req_e14", {31'd0, tx_req}, 32'd1);
    tick();
    chk("tmo_err_e15", {31'd0, err},    32'd1);
    chk("tmo_req_e15", {31'd0, tx_req}, 32'd1);
    tick();
    tick();
    chk("tmo_err_sticky", {31'd0, err},    32'd1);
    chk("tmo_busy",       {31'd0, busy},   32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo_err_clr", {31'd0, err},    32'd0);
    chk("tmo_req_clr", {31'd0, tx_req}, 32'd1);
    $display("timeout err cleared req=%0b", tx_req);

    // ack arrives late, then reset while in REL
    ack_force = 1'b1;
    tick();
    tick();
    chk("rel_pre_req", {31'd0, tx_req}, 32'd1);
    tick();
    chk("rel_req", {31'd0, tx_req}, 32'd0);
    chk("rel_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req",   {31'd0, tx_req},    32'd0);
    chk("arst_done",  {31'd0, done},      32'd0);
    chk("arst_busy",  {31'd0, busy},      32'd0);
    chk("arst_data",  tx_data,            32'd0);
    chk("arst_ready", {31'd0, src_ready}, 32'd1);
    ack_force = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // normal transfer after reset
    loop_en   = 1'b1;
    src_valid = 1'b1;
    src_data  = 32'h0000_0055;
    for (int e = 0; e < 7; e++) begin
      tick();
      if (e == 0) src_valid = 1'b0;
      chk($sformatf("post_req_e%0d", e),  {31'd0, tx_req}, {31'd0, (e < 3)});
      chk($sformatf("post_done_e%0d", e), {31'd0, done},   {31'd0, (e == 6)});
      chk($sformatf("post_data_e%0d", e), tx_data,         32'h0000_0055);
      $display("post e=%0d req=%0b done=%0b data=%h", e, tx_req, done, tx_data);
    end
    chk("post_err", {31'd0, err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cdc_hs_tx.md
# cdc_hs_tx

Source-domain end of a four-phase req/ack clock-domain-crossing handshake. It accepts one data word per transfer on a valid/ready interface and presents it on `tx_req`/`tx_data` to a receiver in an unrelated clock domain. It synchronises the returning `tx_ack` internally and reports completion and timeout status. It sits on every MCU path that sends control/data words (e.g. interrupt vectors, config writes) into another clock domain.

## Interface
- `DW`, 32: data word width.
- `TMO_W`, 8: timeout counter width; timeout fires after 2^TMO_W−1 cycles in REQ.

- `clk`  in  1  source-domain clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `src_valid`  in  1  word available.
- `src_ready`  out  1  block can accept; transfer on `src_valid & src_ready` at a rising edge.
- `src_data`  in  DW  word to send.
- `tx_req`  out  1  handshake request to destination domain (registered).
- `tx_data`  out  DW  held word (registered), stable whenever `tx_req` is high or ack is outstanding.
- `tx_ack`  in  1  acknowledge from destination domain; asynchronous to `clk`.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  single-cycle pulse on handshake completion.
- `err`  out  1  sticky timeout flag.
- `err_clr`  in  1  clears `err`.

## Operation
- `tx_ack` passes through a two-flop synchroniser (reset 0), giving `ack_s`. No other use of raw `tx_ack`.
- FSM states: IDLE, REQ, REL.
  - IDLE: `src_ready = ~ack_s`. On accept, `tx_data <= src_data`, `tx_req <= 1`, go to REQ.
  - REQ: when `ack_s == 1`, `tx_req <= 0`, go to REL.
  - REL: when `ack_s == 0`, go to IDLE, `done <= 1` for one cycle.
- `src_ready` is combinational from state and `ack_s`. It is 0 in REQ and REL.
- If `ack_s` is high in IDLE (stale or spurious ack), no word is accepted until `ack_s` returns low. The FSM stays in IDLE.
- `tx_data` is updated only on accept. It holds its value through REQ, REL and the following IDLE.
- Timeout counter (TMO_W bits):
  - Clears on entry to REQ and increments each cycle in REQ. It saturates at all-ones.
  - The cycle it reaches all-ones, `err <= 1`. The FSM keeps waiting; there is no abort.
  - `err_clr` clears `err`. If `err_clr` and a new saturation occur in the same cycle, set wins.
- Reset values: state IDLE, `tx_req` 0, `tx_data` 0, `done` 0, `err` 0, counter 0, sync flops 0. Consequently `src_ready` is 1 and `busy` is 0 out of reset.
- Reset mid-transfer drops `tx_req` immediately (asynchronous) and discards the word. The destination side is reset by the same system reset; there is no recovery protocol.

## Timing
- Accept at edge 0 → `tx_req` and `tx_data` valid after edge 0.
- `tx_ack` rising before edge t → `ack_s` high after edge t+1 → REL and `tx_req` low after edge t+2.
- Falling ack has the same timing: 2 sync edges, then IDLE and `done` after the next edge.
- With a zero-delay loopback (`tx_ack = tx_req`):
  - `tx_req` low after edge 3.
  - IDLE and `done` high after edge 6.
  - Next accept at edge 7, giving a minimum period of 7 cycles per word.
- `done` and `src_ready` are high in the same cycle. A `src_valid` held high is accepted at that edge.

## Structure
- Shared MCU defines header holds:
  - the state encoding constants (IDLE=2'd0, REQ=2'd1, REL=2'd2);
  - default `DW` and `TMO_W`.
- One sub-module: the team's standard two-stage synchroniser cell `dff_chain2`, instantiated once for `tx_ack`.
- FSM, data register and timeout counter are local.
- A matching receiver block, `cdc_hs_rx`, is a separate module and not part of this block.

## Test plan
- Reset release, `src_valid=0`:
  - `src_ready=1`, `busy=0`, `tx_req=0`, `tx_data=0`, `err=0`.
- Zero-delay loopback, `src_data=32'hA5A5_0001` accepted at edge 0:
  - `tx_req` high after edges 0–2 and low after edge 3.
  - `done` pulses after edge 6.
  - `tx_data` stays `32'hA5A5_0001` throughout.
- `src_valid` held high with 3 words (`32'h1`, `32'h2`, `32'h3`) in loopback:
  - accepts at edges 0, 7 and 14;
  - exactly 3 `done` pulses;
  - `tx_data` sequence 1, 2, 3.
- `tx_ack` forced high while in IDLE:
  - `src_ready=0`, no accept.
  - Release `tx_ack` → `src_ready` returns to 1 two edges later.
- `TMO_W=4`, `tx_ack` tied 0 after accept:
  - `err` rises 15 cycles after entering REQ.
  - `tx_req` stays 1.
  - `err_clr` pulse → `err=0`.
- Assert `rst_n=0` in REL:
  - `tx_req` and `done` are 0 immediately and the state returns to IDLE.
  - After release, a new transfer completes normally.
